// File: rtl/command_scheduler_pkg.sv
// Shared Illusion definitions for the command scheduler: FSM states, command
// opcodes, opcode field position and the bus widths taken from the global defines.
`ifndef MAIN_MEMORY_BUS_ADDR_WIDTH
`define MAIN_MEMORY_BUS_ADDR_WIDTH 32
`endif
`ifndef COMMAND_DEPTH
`define COMMAND_DEPTH 32
`endif

package command_scheduler_pkg;

  localparam int unsigned ADDR_WIDTH    = `MAIN_MEMORY_BUS_ADDR_WIDTH;
  localparam int unsigned COMMAND_WIDTH = `COMMAND_DEPTH;

  localparam int unsigned OPCODE_MSB   = COMMAND_WIDTH - 1;
  localparam int unsigned OPCODE_WIDTH = 8;

  localparam logic [OPCODE_WIDTH-1:0] COMMAND_OPCODE_END = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] COMMAND_OPCODE_NOP = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_WAIT_FETCH,
    S_READ,
    S_CAPTURE,
    S_DISPATCH,
    S_COMPLETE
  } sched_state_e;

  function automatic logic [OPCODE_WIDTH-1:0] command_opcode(input logic [COMMAND_WIDTH-1:0] word);
    return word[OPCODE_MSB -: OPCODE_WIDTH];
  endfunction

endpackage

// File: rtl/command_scheduler_queue.sv
// command_pointer_queue: synchronous FIFO of command-buffer base pointers.
// Power-of-two depth; async active-low reset empties it.
module command_pointer_queue
  import command_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ADDR_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the registered count, so a same-cycle pop never frees a slot for a push
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/command_scheduler.sv
// command_scheduler: launches the fetcher per queued pointer and streams buffer words to decode.
// Optional ILLUSION_SCHEDULER_NOP_FILTER_EN drops NOP words instead of dispatching them.
module command_scheduler
  import command_scheduler_pkg::*;
#(
  parameter int unsigned COMMAND_BUFFER_SIZE = 64,
  parameter int unsigned QUEUE_DEPTH         = 4
) (
  input  logic                                   aClock,
  input  logic                                   aReset,
  input  logic [ADDR_WIDTH-1:0]                  aSubmitPointer,
  input  logic                                   aSubmitValid,
  output logic                                   anOutSubmitReady,
  output logic [ADDR_WIDTH-1:0]                  anOutCommandPointer,
  output logic                                   anOutExecute,
  input  logic                                   aFetchReady,
  output logic [$clog2(COMMAND_BUFFER_SIZE)-1:0] anOutCommandIndex,
  output logic                                   anOutCommandRead,
  input  logic [COMMAND_WIDTH-1:0]               aCommandData,
  output logic [COMMAND_WIDTH-1:0]               anOutDispatchData,
  output logic                                   anOutDispatchValid,
  input  logic                                   aDispatchReady,
  output logic                                   anOutBusy,
  output logic [15:0]                            anOutCompletedCount
);

  localparam int unsigned IDX_W = $clog2(COMMAND_BUFFER_SIZE);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(COMMAND_BUFFER_SIZE - 1);

  sched_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pointer_q, pointer_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [COMMAND_WIDTH-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic [15:0]              count_q, count_d;

  logic                     q_push, q_pop, q_full, q_empty;
  logic [ADDR_WIDTH-1:0]    q_head;
  logic [OPCODE_WIDTH-1:0]  opcode;
  logic                     consume_nop;
  logic                     advance;

  assign anOutSubmitReady = aReset && !q_full;
  assign q_push           = aSubmitValid && anOutSubmitReady;
  assign opcode           = command_opcode(aCommandData);

`ifdef ILLUSION_SCHEDULER_NOP_FILTER_EN
  assign consume_nop = (opcode == COMMAND_OPCODE_NOP);
`else
  assign consume_nop = 1'b0;
`endif

  command_pointer_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clk_i   (aClock),
    .rst_ni  (aReset),
    .push_i  (q_push),
    .data_i  (aSubmitPointer),
    .pop_i   (q_pop),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    state_d   = state_q;
    pointer_d = pointer_q;
    index_d   = index_q;
    data_d    = data_q;
    valid_d   = valid_q;
    count_d   = count_q;
    q_pop     = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          pointer_d = q_head;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        index_d = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE:     state_d = S_WAIT_FETCH;
      S_WAIT_FETCH: if (aFetchReady) state_d = S_READ;
      S_READ:       state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (opcode == COMMAND_OPCODE_END) begin
          state_d = S_COMPLETE;
        end else if (consume_nop) begin
          advance = 1'b1;
        end else begin
          data_d  = aCommandData;
          valid_d = 1'b1;
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (aDispatchReady) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      S_COMPLETE: begin
        count_d = count_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A filtered NOP and a handshaken word share one advance path so both stop at the last index
    if (advance) begin
      if (index_q == LAST_INDEX) begin
        state_d = S_COMPLETE;
      end else begin
        index_d = index_q + 1'b1;
        state_d = S_READ;
      end
    end
  end

  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      state_q   <= S_IDLE;
      pointer_q <= '0;
      index_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pointer_q <= pointer_d;
      index_q   <= index_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign anOutCommandPointer = pointer_q;
  assign anOutExecute        = (state_q == S_LAUNCH);
  assign anOutCommandRead    = (state_q == S_READ);
  assign anOutCommandIndex   = index_q;
  assign anOutDispatchData   = data_q;
  assign anOutDispatchValid  = valid_q;
  assign anOutBusy           = (state_q != S_IDLE) || !q_empty;
  assign anOutCompletedCount = count_q;

endmodule
